// File: rtl/demux_pkg.sv
// demux_pkg: shared lane count, select width and lane index type
package demux_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] lane_idx_t;
endpackage

// File: rtl/demux_1x4_stream_if.sv
// demux_1x4_stream_if: input beat and per-lane output handshake bundle
interface demux_1x4_stream_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0]       in_data;
  lane_idx_t               in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_valid;
  logic [LANES-1:0]        out_ready;
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_lane_reg.sv
// demux_lane_reg: one-entry lane register; a load in the same cycle as a drain keeps it full
module demux_lane_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic              r_full;
  logic [DATA_W-1:0] r_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_ready) begin
      r_full <= 1'b0;
    end
  end
  assign o_valid = r_full;
  assign o_data  = r_data;
endmodule

// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: registered 1-to-4 stream demux with per-lane holding registers
// Optional DEMUX_ROUND_ROBIN_EN: lane picked by an internal pointer instead of in_sel.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic rst,
  demux_1x4_stream_if.slave io_bus
);
  logic [LANES-1:0]  w_full;
  logic [LANES-1:0]  w_load;
  logic [DATA_W-1:0] w_data [LANES];
  lane_idx_t         w_dst;
  logic              w_ready;
  logic              w_accept;
`ifdef DEMUX_ROUND_ROBIN_EN
  lane_idx_t r_rr_ptr;
  // Pointer advances only on accept, so it waits on a stalled lane and order stays strict.
  always_ff @(posedge clk) begin
    r_rr_ptr <= rst ? '0 : r_rr_ptr + lane_idx_t'(w_accept);
  end
  assign w_dst = r_rr_ptr;
`else
  assign w_dst = io_bus.in_sel;
`endif
  always_comb begin
    w_ready          = ~w_full[w_dst] | io_bus.out_ready[w_dst];
    w_accept         = io_bus.in_valid & w_ready;
    w_load           = w_accept ? LANES'(1) << w_dst : '0;
    io_bus.in_ready  = w_ready;
    io_bus.out_valid = w_full;
    io_bus.out_data  = '0;
    for (int i = 0; i < LANES; i++) io_bus.out_data[i*DATA_W +: DATA_W] = w_data[i];
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane_reg #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (io_bus.in_data),
      .i_ready (io_bus.out_ready[k]),
      .o_valid (w_full[k]),
      .o_data  (w_data[k])
    );
  end
endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb_demux_1x4_stream: directed plus random checks against a per-lane slot model
module tb_demux_1x4_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [15:0] m_data [4];
  bit          m_full [4];
  int          m_ptr;
  bit          last_acc;
  demux_1x4_stream_if #(.DATA_W(16)) bus ();
  demux_1x4_stream #(.DATA_W(16)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane(input int k);
    return bus.out_data[k*16 +: 16];
  endfunction

  function automatic logic [63:0] m_out_data();
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = m_data[k];
    return r;
  endfunction

  function automatic logic [3:0] m_out_valid();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_full[k];
    return r;
  endfunction

  // Each lane is a one-slot buffer: a pending sample leaves when downstream is ready,
  // and the slot takes a new sample if it is empty or emptying this cycle.
  task automatic step();
    int  d;
    bit  rdy, acc;
`ifdef DEMUX_ROUND_ROBIN_EN
    d = m_ptr;
`else
    d = int'(bus.in_sel);
`endif
    rdy = !m_full[d] || bus.out_ready[d];
    acc = bus.in_valid && rdy && !rst;
    #1;
    chk("in_ready", {63'b0, bus.in_ready}, {63'b0, rdy});
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 0;
        m_data[k] = '0;
      end
      m_ptr = 0;
    end else begin
      for (int k = 0; k < 4; k++) if (m_full[k] && bus.out_ready[k]) m_full[k] = 0;
      if (acc) begin
        m_full[d] = 1;
        m_data[d] = bus.in_data;
        m_ptr = (m_ptr + 1) % 4;
      end
    end
    last_acc = acc;
    #1;
    chk("out_valid", {60'b0, bus.out_valid}, {60'b0, m_out_valid()});
    chk("out_data", bus.out_data, m_out_data());
  endtask

  task automatic drive(input bit v, input int sel, input logic [15:0] data);
    bus.in_valid = v;
    bus.in_sel   = 2'(sel);
    bus.in_data  = data;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0;
      m_data[k] = '0;
    end
    m_ptr = 0;
    last_acc = 0;
    bus.out_ready = 4'b0000;
    drive(0, 0, 16'h0);
    step();
    chk("rst_valid", {60'b0, bus.out_valid}, 64'h0);
    chk("rst_data", bus.out_data, 64'h0);
    chk("rst_ready", {63'b0, bus.in_ready}, 64'h1);
    rst = 1'b0;
`ifdef DEMUX_ROUND_ROBIN_EN
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 16'(16'hA0 + i));
      step();
      chk("rr_lane_valid", {60'b0, bus.out_valid}, {60'b0, 4'(1 << (i % 4))});
      chk("rr_lane_data", {48'b0, lane(i % 4)}, {48'b0, 16'(16'hA0 + i)});
    end
    drive(0, 0, 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 16'(16'hB0 + i));
      step();
    end
    drive(1, 0, 16'hB5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_stall_ready", {63'b0, bus.in_ready}, 64'h0);
      chk("rr_stall_hold", {48'b0, lane(1)}, 64'hB1);
    end
    bus.out_ready = 4'b1111;
    step();
    chk("rr_resume_lane1", {48'b0, lane(1)}, 64'hB5);
    drive(1, 3, 16'hB6);
    step();
    chk("rr_next_lane2", {48'b0, lane(2)}, 64'hB6);
    chk("rr_next_valid", {60'b0, bus.out_valid}, 64'h4);
`else
    drive(1, 2, 16'h1234);
    step();
    chk("first_valid", {60'b0, bus.out_valid}, 64'h4);
    chk("first_data", bus.out_data, 64'h0000_1234_0000_0000);
    drive(1, 1, 16'h5555);
    step();
    drive(1, 1, 16'h7777);
    step();
    chk("stall_ready", {63'b0, bus.in_ready}, 64'h0);
    chk("stall_hold", {48'b0, lane(1)}, 64'h5555);
    drive(1, 3, 16'h00AB);
    step();
    chk("other_valid3", {63'b0, bus.out_valid[3]}, 64'h1);
    chk("other_data3", {48'b0, lane(3)}, 64'h00AB);
    drive(0, 0, 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 16'(i));
      step();
      chk("b2b_valid0", {63'b0, bus.out_valid[0]}, 64'h1);
      chk("b2b_data0", {48'b0, lane(0)}, 64'(i));
    end
    drive(0, 0, 16'h0);
    step();
    chk("b2b_drained", {63'b0, bus.out_valid[0]}, 64'h0);
    bus.out_ready = 4'b0000;
    drive(1, 0, 16'h1111);
    step();
    drive(1, 2, 16'h2222);
    step();
    chk("pre_rst_valid", {60'b0, bus.out_valid}, 64'h5);
    drive(1, 1, 16'h3333);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {60'b0, bus.out_valid}, 64'h0);
    chk("mid_rst_data", bus.out_data, 64'h0);
    chk("mid_rst_ready", {63'b0, bus.in_ready}, 64'h1);
    rst = 1'b0;
`endif
    drive(0, 0, 16'h0);
    last_acc = 1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || last_acc) drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), 16'($urandom));
      bus.out_ready = 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
